anc_mode_seq: RTL and testbench

Top-level mode sequencer for the ANC core. It owns the shared secondary-path coefficient RAM (`sz_ram`) and the speaker output. It runs the flow: clear `sz_ram`, then offline secondary-path identification (OFZ), then settle, then online FxLMS operation. It holds OFZ in reset whenever OFZ is not active, because OFZ's completion flag is self-latching. It sits between the audio codec interface, the OFZ block, the online FxLMS filter and the `sz_ram` single-port RAM.

---
 rtl/anc_pkg.sv | 14 +
 rtl/sz_port_mux.sv | 25 ++
 rtl/anc_mode_seq.sv | 92 +++++++++
 tb/tb_anc_mode_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// anc_pkg: shared ANC types and sizing for the mode sequencer and its RAM port mux.
package anc_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        OFFLINE = 3'd2,
        SETTLE  = 3'd3,
        ONLINE  = 3'd4
    } state_t;
    localparam int SZ_TAPS = 127;
    localparam int SZ_AW   = 7;
    localparam int SZ_DW   = 20;
    localparam int SMP_W   = 16;
endpackage

// File: rtl/sz_port_mux.sv
// sz_port_mux: selects who drives the shared sz_ram port (clear sweep, OFZ or FxLMS read) by state.
module sz_port_mux
    import anc_pkg::*;
#(
    parameter int AW = SZ_AW,
    parameter int DW = SZ_DW
) (
    input  state_t        state,
    input  logic [AW-1:0] clr_addr,
    input  logic          ofz_wren,
    input  logic [AW-1:0] ofz_addr,
    input  logic [DW-1:0] ofz_wdata,
    input  logic [AW-1:0] anc_rd_addr,
    output logic          ram_wren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata
);
    always_comb begin
        ram_wren  = (state == CLEAR) || (state == OFFLINE && ofz_wren);
        ram_addr  = state == CLEAR   ? clr_addr :
                    state == OFFLINE ? ofz_addr :
                    state == ONLINE  ? anc_rd_addr : '0;
        ram_wdata = state == OFFLINE ? ofz_wdata : '0;
    end
endmodule

// File: rtl/anc_mode_seq.sv
// anc_mode_seq: sequences sz_ram clear, offline secondary-path identification, settle and online FxLMS,
// owning the sz_ram port and the speaker output.
module anc_mode_seq
    import anc_pkg::*;
#(
    parameter int TAPS           = SZ_TAPS,
    parameter int AW             = SZ_AW,
    parameter int DW             = SZ_DW,
    parameter int SETTLE_FRAMES  = 256,
    parameter int TIMEOUT_FRAMES = 16384
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    audio_rx_down,
    input  logic                    start,
    input  logic                    retrain,
    input  logic                    ofz_ok,
    output logic                    ofz_rst_n,
    input  logic                    ofz_wren,
    input  logic [AW-1:0]           ofz_addr,
    input  logic [DW-1:0]           ofz_wdata,
    input  logic [AW-1:0]           anc_rd_addr,
    output logic                    ram_wren,
    output logic [AW-1:0]           ram_addr,
    output logic [DW-1:0]           ram_wdata,
    input  logic signed [SMP_W-1:0] ofz_vn,
    input  logic signed [SMP_W-1:0] anc_yn,
    output logic signed [SMP_W-1:0] spk_out,
    output logic [2:0]              mode,
    output logic                    online_en,
    output logic                    err
);
    localparam int FMAX = (TIMEOUT_FRAMES > SETTLE_FRAMES) ? TIMEOUT_FRAMES : SETTLE_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    state_t        state, next;
    logic [AW-1:0] clr_addr;
    logic [FW-1:0] frame_cnt;
    logic          restart, entry;

    assign restart = retrain && state != IDLE;
    // A retrain re-entering CLEAR counts as a fresh entry, so counters restart too.
    assign entry   = (next != state) || restart;
    assign mode    = state;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? CLEAR : IDLE;
            CLEAR:   next = clr_addr == AW'(TAPS - 1) ? OFFLINE : CLEAR;
            OFFLINE: next = ofz_ok ? SETTLE : frame_cnt >= FW'(TIMEOUT_FRAMES) ? IDLE : OFFLINE;
            SETTLE:  next = frame_cnt >= FW'(SETTLE_FRAMES) ? ONLINE : SETTLE;
            default: next = state;
        endcase
        if (restart) next = CLEAR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_addr  <= '0;
            frame_cnt <= '0;
            ofz_rst_n <= 1'b0;
            spk_out   <= '0;
            online_en <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next;
            clr_addr  <= (state == CLEAR && !entry) ? clr_addr + 1'b1 : '0;
            frame_cnt <= entry ? '0 : frame_cnt + FW'(audio_rx_down && frame_cnt != '1);
            ofz_rst_n <= next == OFFLINE;
            online_en <= next == ONLINE;
            err       <= (state == OFFLINE && next == IDLE) || (err && !(state == IDLE && start));
            spk_out   <= entry          ? '0 :
                         !audio_rx_down ? spk_out :
                         state == OFFLINE ? ofz_vn :
                         state == ONLINE  ? anc_yn : '0;
        end
    end

    sz_port_mux #(.AW(AW), .DW(DW)) u_mux (
        .state       (state),
        .clr_addr    (clr_addr),
        .ofz_wren    (ofz_wren),
        .ofz_addr    (ofz_addr),
        .ofz_wdata   (ofz_wdata),
        .anc_rd_addr (anc_rd_addr),
        .ram_wren    (ram_wren),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata)
    );
endmodule

// File: tb/tb_anc_mode_seq.sv
// tb_anc_mode_seq: directed-vector bench for the ANC mode sequencer.
module tb_anc_mode_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        audio_rx_down = 1'b0, start = 1'b0, retrain = 1'b0, ofz_ok = 1'b0;
    logic        ofz_wren = 1'b0;
    logic [6:0]  ofz_addr = '0, anc_rd_addr = '0;
    logic [19:0] ofz_wdata = '0;
    logic [15:0] ofz_vn = '0, anc_yn = '0;
    logic        ofz_rst_n, ram_wren, online_en, err;
    logic [6:0]  ram_addr;
    logic [19:0] ram_wdata;
    logic [15:0] spk_out;
    logic [2:0]  mode;
    int          n_chk = 0, n_fail = 0, bad_addr;

    anc_mode_seq dut (
        .clk(clk), .rst_n(rst_n), .audio_rx_down(audio_rx_down), .start(start),
        .retrain(retrain), .ofz_ok(ofz_ok), .ofz_rst_n(ofz_rst_n), .ofz_wren(ofz_wren),
        .ofz_addr(ofz_addr), .ofz_wdata(ofz_wdata), .anc_rd_addr(anc_rd_addr),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ofz_vn(ofz_vn), .anc_yn(anc_yn), .spk_out(spk_out), .mode(mode),
        .online_en(online_en), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 32'(mode), 0);
        check({tag, "_ofz_rst_n"}, 32'(ofz_rst_n), 0);
        check({tag, "_ram_wren"}, 32'(ram_wren), 0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
        check({tag, "_spk_out"}, 32'(spk_out), 0);
        check({tag, "_online_en"}, 32'(online_en), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Walks a sweep that has just started at address 0 and lands on the first OFFLINE cycle.
    task automatic clear_sweep(input string tag);
        bad_addr = 0;
        for (int i = 0; i < 127; i++) begin
            if (mode != 3'd1 || !ram_wren || ram_addr != 7'(i) || ram_wdata != 0) bad_addr++;
            step(1);
        end
        check({tag, "_sweep_bad_cycles"}, 32'(bad_addr), 0);
        check({tag, "_mode_offline"}, 32'(mode), 2);
        check({tag, "_ofz_rst_n"}, 32'(ofz_rst_n), 1);
    endtask

    initial begin
        step(2);
        check_reset_vals("reset");
        rst_n = 1'b1;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("clr_ofz_rst_n", 32'(ofz_rst_n), 0);
        clear_sweep("t1");
        ofz_wren = 1'b1; ofz_addr = 7'd5; ofz_wdata = 20'h12345; ofz_vn = 16'h1234;
        #1;
        check("off_wren", 32'(ram_wren), 1);
        check("off_addr", 32'(ram_addr), 5);
        check("off_wdata", 32'(ram_wdata), 32'h12345);
        check("off_spk_pre", 32'(spk_out), 0);
        audio_rx_down = 1'b1;
        step(1);
        audio_rx_down = 1'b0; ofz_vn = 16'h5678;
        check("off_spk_strobe", 32'(spk_out), 32'h1234);
        step(1);
        check("off_spk_hold", 32'(spk_out), 32'h1234);
        ofz_ok = 1'b1;
        step(1);
        ofz_ok = 1'b0;
        check("settle_mode", 32'(mode), 3);
        check("settle_spk", 32'(spk_out), 0);
        check("settle_ofz_rst_n", 32'(ofz_rst_n), 0);
        check("settle_wren", 32'(ram_wren), 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("settle_start_ignored", 32'(mode), 3);
        audio_rx_down = 1'b1;
        step(255);
        check("settle_255", 32'(mode), 3);
        step(1);
        audio_rx_down = 1'b0;
        check("settle_256_edge", 32'(mode), 3);
        step(1);
        anc_rd_addr = 7'h33; anc_yn = 16'hbeef;
        #1;
        check("online_mode", 32'(mode), 4);
        check("online_en", 32'(online_en), 1);
        check("online_addr", 32'(ram_addr), 32'h33);
        check("online_wren", 32'(ram_wren), 0);
        audio_rx_down = 1'b1;
        step(1);
        audio_rx_down = 1'b0;
        check("online_spk", 32'(spk_out), 32'hbeef);
        retrain = 1'b1;
        step(1);
        retrain = 1'b0;
        check("rt_mode", 32'(mode), 1);
        check("rt_online_en", 32'(online_en), 0);
        check("rt_addr", 32'(ram_addr), 0);
        check("rt_spk", 32'(spk_out), 0);
        step(10);
        check("rt_mid_addr", 32'(ram_addr), 10);
        retrain = 1'b1;
        step(1);
        retrain = 1'b0;
        check("rt2_mode", 32'(mode), 1);
        check("rt2_addr", 32'(ram_addr), 0);
        clear_sweep("t5");
        ofz_ok = 1'b0; audio_rx_down = 1'b1;
        step(16383);
        check("to_16383", 32'(mode), 2);
        step(1);
        audio_rx_down = 1'b0;
        check("to_16384_edge", 32'(mode), 2);
        check("to_err_pre", 32'(err), 0);
        check("to_spk_pre", 32'(spk_out), 32'h5678);
        step(1);
        check("to_mode", 32'(mode), 0);
        check("to_err", 32'(err), 1);
        check("to_spk", 32'(spk_out), 0);
        check("to_ofz_rst_n", 32'(ofz_rst_n), 0);
        retrain = 1'b1;
        step(1);
        retrain = 1'b0;
        check("idle_retrain_ignored", 32'(mode), 0);
        check("idle_err_kept", 32'(err), 1);
        start = 1'b1; retrain = 1'b1;
        step(1);
        start = 1'b0; retrain = 1'b0;
        check("restart_mode", 32'(mode), 1);
        check("restart_err", 32'(err), 0);
        clear_sweep("t4");
        audio_rx_down = 1'b1; ofz_vn = 16'h0777;
        step(1);
        audio_rx_down = 1'b0;
        check("pre_rst_spk", 32'(spk_out), 32'h0777);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
